// File: rtl/pixel_clock_gen_multi.sv
// Multi-channel fractional pixel-clock generator: each channel divides Clock by
// Fsys/Fcrt with a phase accumulator and has its own start/stop/reconfig FSM.
module pixel_clock_gen_multi #(
    parameter int unsigned SystemClockSize = 10,
    parameter int unsigned NumChannels     = 2
) (
    input  logic                                   Clock,
    input  logic                                   Reset,
    input  logic [SystemClockSize-1:0]             SystemClockFreq,
    input  logic [NumChannels*SystemClockSize-1:0] CRTClockFreq,
    input  logic [NumChannels-1:0]                 Load,
    input  logic [NumChannels-1:0]                 Enable,
    output logic [NumChannels-1:0]                 PixelClock,
    output logic [NumChannels-1:0]                 PixelTick,
    output logic [NumChannels-1:0]                 Running,
    output logic [NumChannels-1:0]                 ConfigError
);
    localparam int unsigned W = SystemClockSize;

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;

    logic sys_nonzero;
    assign sys_nonzero = (SystemClockFreq != '0);

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        state_e       state_q, state_d;
        logic [W:0]   acc_q, acc_d;
        logic [W-1:0] fsys_q, fsys_d, fcrt_q, fcrt_d;
        logic [W-1:0] fsys_sh_q, fsys_sh_d, fcrt_sh_q, fcrt_sh_d;
        logic         pend_q, pend_d;
        logic         clk_q, clk_d;
        logic         tick_q;
        logic         err_q, err_d;
        logic         run;

        logic [W-1:0] fcrt_in;
        logic [W:0]   sum;
        logic         load_valid, act_valid, stepping, toggle, fall, apply;

        assign fcrt_in    = CRTClockFreq[g*W +: W];
        assign load_valid = (fcrt_in != '0) && sys_nonzero
                            && ({fcrt_in, 1'b0} <= {1'b0, SystemClockFreq});
        assign act_valid  = (fcrt_q != '0) && (fsys_q != '0)
                            && ({fcrt_q, 1'b0} <= {1'b0, fsys_q});

        // Leaving RUN while low skips the accumulator so no runt pulse appears.
        assign stepping = (state_q == STOPPING)
                          || ((state_q == RUN) && (Enable[g] || clk_q));
        assign sum      = acc_q + {fcrt_q, 1'b0};
        assign toggle   = stepping && (sum >= {1'b0, fsys_q});
        assign fall     = toggle && clk_q;

        always_ff @(posedge Clock) begin
            if (!Reset) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                IDLE: begin
                    if (Enable[g] && act_valid) state_d = RUN;
                end
                RUN: begin
                    if (!Enable[g]) state_d = (clk_q && !fall) ? STOPPING : IDLE;
                end
                STOPPING: begin
                    if (Enable[g])  state_d = RUN;
                    else if (fall)  state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            run = (state_q != IDLE);
        end

        // Pending shadow is committed on a falling edge or whenever the channel idles.
        assign apply = pend_q && (fall || (state_d == IDLE));

        always_comb begin
            acc_d     = acc_q;
            clk_d     = clk_q;
            fsys_d    = fsys_q;
            fcrt_d    = fcrt_q;
            fsys_sh_d = fsys_sh_q;
            fcrt_sh_d = fcrt_sh_q;
            pend_d    = pend_q;
            err_d     = err_q;

            if (state_q == IDLE) begin
                clk_d = 1'b0;
                if (state_d == RUN)            acc_d = '0;
                if (Enable[g] && !act_valid)   err_d = 1'b1;
            end else if (stepping) begin
                acc_d = toggle ? (sum - {1'b0, fsys_q}) : sum;
                if (toggle) clk_d = ~clk_q;
            end else begin
                clk_d = 1'b0;
            end

            if (apply) begin
                fsys_d = fsys_sh_q;
                fcrt_d = fcrt_sh_q;
                acc_d  = '0;
                pend_d = 1'b0;
            end

            if (Load[g]) begin
                if (!load_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d     = 1'b0;
                    fsys_sh_d = SystemClockFreq;
                    fcrt_sh_d = fcrt_in;
                    if (state_q == IDLE) begin
                        fsys_d = SystemClockFreq;
                        fcrt_d = fcrt_in;
                        pend_d = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
        end

        always_ff @(posedge Clock) begin
            if (!Reset) begin
                acc_q     <= '0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
                fsys_q    <= '0;
                fcrt_q    <= '0;
                fsys_sh_q <= '0;
                fcrt_sh_q <= '0;
                pend_q    <= 1'b0;
                err_q     <= 1'b0;
            end else begin
                acc_q     <= acc_d;
                clk_q     <= clk_d;
                tick_q    <= clk_d & ~clk_q;
                fsys_q    <= fsys_d;
                fcrt_q    <= fcrt_d;
                fsys_sh_q <= fsys_sh_d;
                fcrt_sh_q <= fcrt_sh_d;
                pend_q    <= pend_d;
                err_q     <= err_d;
            end
        end

        assign PixelClock[g]  = clk_q;
        assign PixelTick[g]   = tick_q;
        assign Running[g]     = run;
        assign ConfigError[g] = err_q;
    end

endmodule

// File: tb/tb_pixel_clock_gen_multi.sv
// Bench for pixel_clock_gen_multi: directed scenarios plus randomized traffic
// against a model that derives toggle times from floor(n*2*Fcrt/Fsys).
module tb_pixel_clock_gen_multi;
    localparam int W = 10;
    localparam int N = 2;

    logic           Clock = 1'b0;
    logic           Reset;
    logic [W-1:0]   SystemClockFreq;
    logic [N*W-1:0] CRTClockFreq;
    logic [N-1:0]   Load;
    logic [N-1:0]   Enable;
    logic [N-1:0]   PixelClock;
    logic [N-1:0]   PixelTick;
    logic [N-1:0]   Running;
    logic [N-1:0]   ConfigError;

    always #5 Clock = ~Clock;

    pixel_clock_gen_multi #(.SystemClockSize(W), .NumChannels(N)) dut (
        .Clock(Clock), .Reset(Reset), .SystemClockFreq(SystemClockFreq),
        .CRTClockFreq(CRTClockFreq), .Load(Load), .Enable(Enable),
        .PixelClock(PixelClock), .PixelTick(PixelTick),
        .Running(Running), .ConfigError(ConfigError)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: 0 = idle, 1 = run, 2 = stopping; m_n counts steps since phase reset
    int     m_st[N];
    longint m_n[N];
    int     m_fs[N], m_fc[N], m_ss[N], m_sc[N];
    bit     m_pend[N], m_clk[N], m_tick[N], m_err[N];

    function automatic bit m_toggle(longint n, int fc, int fs);
        return (((n + 1) * 2 * fc) / fs) != ((n * 2 * fc) / fs);
    endfunction

    task automatic model_step();
        for (int c = 0; c < N; c++) begin
            int f_in, s_in, nst;
            bit en, ld, vin, vact, tog, fall, nclk;
            f_in = int'(CRTClockFreq[c*W +: W]);
            s_in = int'(SystemClockFreq);
            en   = Enable[c];
            ld   = Load[c];
            if (!Reset) begin
                m_st[c] = 0; m_n[c] = 0; m_fs[c] = 0; m_fc[c] = 0; m_ss[c] = 0; m_sc[c] = 0;
                m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_err[c] = 0;
            end else begin
                vact = (m_fc[c] != 0) && (m_fs[c] != 0) && (2 * m_fc[c] <= m_fs[c]);
                vin  = (f_in != 0) && (s_in != 0) && (2 * f_in <= s_in);
                nst  = m_st[c];
                nclk = m_clk[c];
                fall = 0;
                if (m_st[c] == 0) begin
                    nclk = 0;
                    if (en) begin
                        if (vact) begin nst = 1; m_n[c] = 0; end
                        else m_err[c] = 1;
                    end
                end else if (m_st[c] == 1 && !en && !m_clk[c]) begin
                    nst = 0;
                end else begin
                    tog = m_toggle(m_n[c], m_fc[c], m_fs[c]);
                    m_n[c]++;
                    if (tog) nclk = !m_clk[c];
                    fall = tog && m_clk[c];
                    nst  = en ? 1 : (fall ? 0 : 2);
                end
                if (m_pend[c] && (fall || nst == 0)) begin
                    m_fs[c] = m_ss[c]; m_fc[c] = m_sc[c]; m_n[c] = 0; m_pend[c] = 0;
                end
                if (ld) begin
                    if (vin) begin
                        m_err[c] = 0; m_ss[c] = s_in; m_sc[c] = f_in;
                        if (m_st[c] == 0) begin
                            m_fs[c] = s_in; m_fc[c] = f_in; m_pend[c] = 0;
                        end else begin
                            m_pend[c] = 1;
                        end
                    end else begin
                        m_err[c] = 1;
                    end
                end
                m_tick[c] = nclk && !m_clk[c];
                m_clk[c]  = nclk;
                m_st[c]   = nst;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_clk();
        logic [N-1:0] r = '0;
        for (int c = 0; c < N; c++) r[c] = m_clk[c];
        return r;
    endfunction
    function automatic logic [N-1:0] exp_tick();
        logic [N-1:0] r = '0;
        for (int c = 0; c < N; c++) r[c] = m_tick[c];
        return r;
    endfunction
    function automatic logic [N-1:0] exp_run();
        logic [N-1:0] r = '0;
        for (int c = 0; c < N; c++) r[c] = (m_st[c] != 0);
        return r;
    endfunction
    function automatic logic [N-1:0] exp_err();
        logic [N-1:0] r = '0;
        for (int c = 0; c < N; c++) r[c] = m_err[c];
        return r;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge Clock);
        #1;
    endtask

    task automatic load_ch(input int c, input int fs, input int fc);
        SystemClockFreq        = W'(fs);
        CRTClockFreq[c*W +: W] = W'(fc);
        Load[c]                = 1'b1;
        cycle();
        Load[c]                = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Enable = '1; Load = '1;
        SystemClockFreq = 10'd100; CRTClockFreq = {10'd25, 10'd25};
        cycle(); cycle();
        n_checks++;
        if ({PixelClock, PixelTick, Running, ConfigError} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk=%b tick=%b run=%b err=%b required all 0",
                     PixelClock, PixelTick, Running, ConfigError);
        end
        Load = '0; Enable = '0; Reset = 1'b1;
        cycle(); cycle();
        n_checks++;
        if ({PixelClock, Running, ConfigError} !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got clk=%b run=%b err=%b required 0",
                     PixelClock, Running, ConfigError);
        end
    endtask

    task automatic test_unconfigured_enable();
        Enable[0] = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (ConfigError[0] !== 1'b1 || PixelClock[0] !== 1'b0 || Running[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL unconfigured_enable: got err=%b clk=%b run=%b required 1 0 0",
                     ConfigError[0], PixelClock[0], Running[0]);
        end
        Enable[0] = 1'b0;
        cycle();
        n_checks++;
        if (ConfigError[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky: got %b required 1", ConfigError[0]);
        end
    endtask

    task automatic test_basic_rate();
        load_ch(0, 100, 25);
        n_checks++;
        if (ConfigError[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_load_clears_err: got %b required 0", ConfigError[0]);
        end
        Enable[0] = 1'b1;
        cycle();
        n_checks++;
        if (Running[0] !== 1'b1 || PixelClock[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL run_entry: got run=%b clk=%b required 1 0", Running[0], PixelClock[0]);
        end
        for (int k = 1; k <= 16; k++) begin
            logic ec, et;
            cycle();
            ec = ((k >> 1) & 1) == 1;
            et = (k % 4) == 2;
            n_checks++;
            if (PixelClock[0] !== ec || PixelTick[0] !== et || Running[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL div4_pattern k=%0d: got clk=%b tick=%b run=%b required %b %b 1",
                         k, PixelClock[0], PixelTick[0], Running[0], ec, et);
            end
        end
    endtask

    task automatic test_fractional();
        int ticks = 0;
        load_ch(1, 100, 40);
        Enable[1] = 1'b1;
        cycle();
        for (int k = 1; k <= 500; k++) begin
            cycle();
            if (PixelTick[1] === 1'b1) ticks++;
            n_checks++;
            if (PixelClock !== exp_clk() || PixelTick !== exp_tick()) begin
                n_fail++;
                $display("FAIL concurrent k=%0d: got clk=%b tick=%b required %b %b",
                         k, PixelClock, PixelTick, exp_clk(), exp_tick());
            end
        end
        n_checks++;
        if (ticks != 200) begin
            n_fail++;
            $display("FAIL frac_tick_count: got %0d required 200", ticks);
        end
    endtask

    task automatic test_rate_change();
        bit found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (PixelTick[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_rise_ch0: got no tick in 10 cycles required a tick");
        end
        load_ch(0, 100, 10);
        n_checks++;
        if (PixelClock[0] !== 1'b1 || ConfigError[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL old_half_period: got clk=%b err=%b required 1 0", PixelClock[0], ConfigError[0]);
        end
        for (int j = 1; j <= 15; j++) begin
            logic ec, et;
            cycle();
            ec = (j >= 6 && j <= 10);
            et = (j == 6);
            n_checks++;
            if (PixelClock[0] !== ec || PixelTick[0] !== et) begin
                n_fail++;
                $display("FAIL rate_switch j=%0d: got clk=%b tick=%b required %b %b",
                         j, PixelClock[0], PixelTick[0], ec, et);
            end
        end
    endtask

    task automatic test_config_error();
        int rises = 0;
        load_ch(0, 100, 60);
        n_checks++;
        if (ConfigError[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_load_err: got %b required 1", ConfigError[0]);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (PixelTick[0] === 1'b1) rises++;
        end
        n_checks++;
        if (rises != 2) begin
            n_fail++;
            $display("FAIL old_rate_kept: got %0d rises in 20 cycles required 2", rises);
        end
        load_ch(0, 100, 50);
        n_checks++;
        if (ConfigError[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_reload_err: got %b required 0", ConfigError[0]);
        end
        repeat (14) cycle();
        for (int j = 0; j < 8; j++) begin
            logic prev;
            prev = PixelClock[0];
            cycle();
            n_checks++;
            if (PixelClock[0] !== ~prev || PixelTick[0] !== ~prev) begin
                n_fail++;
                $display("FAIL half_clock j=%0d: got clk=%b tick=%b required %b %b",
                         j, PixelClock[0], PixelTick[0], ~prev, ~prev);
            end
        end
    endtask

    task automatic test_stop();
        bit found = 0;
        load_ch(0, 100, 25);
        repeat (10) cycle();
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (PixelTick[0] === 1'b1) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_rise_stop: got no tick in 8 cycles required a tick");
        end
        Enable[0] = 1'b0;
        cycle();
        n_checks++;
        if (Running[0] !== 1'b1 || PixelClock[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stopping_state: got run=%b clk=%b required 1 1", Running[0], PixelClock[0]);
        end
        cycle();
        n_checks++;
        if (Running[0] !== 1'b0 || PixelClock[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_complete: got run=%b clk=%b required 0 0", Running[0], PixelClock[0]);
        end
        repeat (6) begin
            cycle();
            n_checks++;
            if (PixelClock[0] !== 1'b0 || PixelTick[0] !== 1'b0 || Running[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_quiet: got clk=%b tick=%b run=%b required 0 0 0",
                         PixelClock[0], PixelTick[0], Running[0]);
            end
        end
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            if (PixelClock[1] === 1'b0) found = 1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_low_ch1: got no low phase in 8 cycles required one");
        end
        Enable[1] = 1'b0;
        cycle();
        n_checks++;
        if (Running[1] !== 1'b0 || PixelClock[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_while_low: got run=%b clk=%b required 0 0", Running[1], PixelClock[1]);
        end
    endtask

    task automatic test_random();
        Enable = '1;
        for (int i = 0; i < 3000; i++) begin
            int s;
            Reset = ($urandom_range(0, 499) != 0);
            s = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 64));
            SystemClockFreq = W'(s);
            for (int c = 0; c < N; c++) begin
                int f, sel;
                Load[c] = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 29) == 0) Enable[c] = ~Enable[c];
                sel = int'($urandom_range(0, 9));
                if (sel == 0)      f = 0;
                else if (sel == 1) f = int'($urandom_range(0, 64));
                else               f = int'($urandom_range(1, (s / 2 > 1) ? s / 2 : 1));
                CRTClockFreq[c*W +: W] = W'(f);
            end
            cycle();
            n_checks++;
            if (PixelClock !== exp_clk()) begin
                n_fail++;
                $display("FAIL rand_clk i=%0d: got %b required %b", i, PixelClock, exp_clk());
            end
            n_checks++;
            if (PixelTick !== exp_tick()) begin
                n_fail++;
                $display("FAIL rand_tick i=%0d: got %b required %b", i, PixelTick, exp_tick());
            end
            n_checks++;
            if (Running !== exp_run()) begin
                n_fail++;
                $display("FAIL rand_running i=%0d: got %b required %b", i, Running, exp_run());
            end
            n_checks++;
            if (ConfigError !== exp_err()) begin
                n_fail++;
                $display("FAIL rand_err i=%0d: got %b required %b", i, ConfigError, exp_err());
            end
        end
        Load = '0;
    endtask

    initial begin
        Reset = 1'b0; Enable = '0; Load = '0;
        SystemClockFreq = '0; CRTClockFreq = '0;
        test_reset();
        test_unconfigured_enable();
        test_basic_rate();
        test_fractional();
        test_rate_change();
        test_config_error();
        test_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_clock_gen_multi.md
Name: pixel_clock_gen_multi

Overview:
- Multi-channel successor to the single-output pixel-clock divider.
- Generates NumChannels independent square-wave clocks from the system clock, using a fractional phase accumulator, so the average frequency is exact for any ratio, not just integer ones.
- Also provides per-channel start/stop, glitch-free runtime frequency change, a one-cycle rising-edge tick for clock-enable use, and configuration error flags.
- Feeds the VGA/CRT timing and any peripheral needing a derived rate.

Parameters:
- SystemClockSize, 10, width of every frequency word (units are the caller's choice, e.g. MHz; both frequency words must use the same units).
- NumChannels, 2, number of independent output channels (1..8).

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-low reset, sampled on posedge Clock.
- SystemClockFreq  in  SystemClockSize  frequency of Clock; sampled only on Load.
- CRTClockFreq  in  NumChannels*SystemClockSize  requested output frequency per channel; channel i uses bits [i*W +: W].
- Load  in  NumChannels  one-cycle strobe per channel; capture that channel's frequency pair.
- Enable  in  NumChannels  level; run the channel while high.
- PixelClock  out  NumChannels  generated clocks, registered.
- PixelTick  out  NumChannels  one-cycle strobe, high in the cycle PixelClock[i] goes 0->1.
- Running  out  NumChannels  high while the channel is in RUN or STOPPING.
- ConfigError  out  NumChannels  sticky flag; last Load was invalid, or the channel was enabled with no valid configuration.

Behaviour:
- Reset (Reset==0 at posedge):
  - All outputs 0.
  - Accumulators 0.
  - Active and shadow frequency registers 0; pending flags 0.
  - Every state machine goes to IDLE.
  - Reset overrides Load and Enable in the same cycle and aborts any channel mid-period with no completion.
- Per-channel state machine:
  - IDLE: output held low.
  - IDLE -> RUN when Enable=1 and the active config is valid. On entry, acc <= 0.
  - IDLE stays IDLE when Enable=1 with an invalid or zero config; ConfigError <= 1 in that case.
  - RUN -> STOPPING when Enable=0 and PixelClock=1.
  - RUN -> IDLE when Enable=0 and PixelClock=0. Output stays low, so no runt pulse is produced.
  - STOPPING: accumulator keeps running. On the next falling toggle -> IDLE. If Enable returns to 1 before that toggle -> RUN.
- Accumulator (RUN/STOPPING), SystemClockSize+1 bits, per cycle:
  - s = acc + 2*Fcrt_active.
  - If s >= Fsys_active: acc <= s - Fsys_active and PixelClock toggles.
  - Otherwise acc <= s.
  - Invariant: acc < Fsys_active. s never overflows W+1 bits.
- PixelTick: asserted in exactly the cycles where the PixelClock register transitions 0->1. Never asserted in IDLE.
- Config validity: Fcrt != 0, Fsys != 0, and 2*Fcrt <= Fsys.
- Load handling:
  - Invalid Load: ConfigError <= 1. Shadow and active registers unchanged.
  - Valid Load: ConfigError <= 0 and shadow <= inputs.
  - If the channel is IDLE, the valid Load is applied to active in the same cycle.
  - Otherwise a pending flag is set, and the shadow is copied to active at the next falling toggle (1->0). Accumulator is cleared at that point.
  - A Load in the same cycle as a falling toggle is applied at the following falling toggle, not that one.
  - A second Load while pending overwrites the shadow.
- Frequency result:
  - Average output frequency is exactly Fcrt*(Clock frequency)/Fsys.
  - With 2*Fcrt == Fsys the output toggles every cycle (Clock/2, 50% duty).
  - With Fsys/(2*Fcrt) an integer, the output is exactly periodic with 50% duty.
  - Otherwise half-period lengths vary by at most one Clock cycle.
- Channels are fully independent; there is no shared state other than SystemClockFreq.

Test Plan:
- Reset=0 for 2 cycles, with Enable=1 and Load=1 asserted during reset -> all outputs 0; no activity until Reset=1.
- Ch0: Load Fsys=100, Fcrt=25, then Enable -> PixelClock toggles every 2 cycles. First rise is 2 cycles after RUN entry. PixelTick pulses every 4 cycles. Running=1.
- Ch1: Fsys=100, Fcrt=40 -> exactly 4 toggles per 5 cycles (2 periods per 5 cycles); over 500 cycles, exactly 200 PixelTick pulses. Ch0 runs concurrently and is unaffected.
- Ch0 running at 25, Load Fcrt=10 mid-high phase -> current half-period completes at the old rate. After the falling toggle, half-periods are 5 cycles. No glitch at the switch point.
- Load Fcrt=60 with Fsys=100 -> ConfigError=1 and the old rate continues. A subsequent Load Fcrt=50 clears ConfigError, and the output becomes Clock/2.
- Enable drops while PixelClock=1 -> STOPPING; the output falls at its normal toggle, then IDLE with Running=0. Enable while unconfigured after reset -> ConfigError=1 and the output stays 0.
